mash_setpoint_ramp: RTL and testbench

//  Downstream consumer of the JTAG AXI-Lite slave's 32-bit data_out control word. Captures the word,

---
 rtl/mash_setpoint_ramp.sv | 141 ++++++++++++++
 tb/tb_mash_setpoint_ramp.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mash_setpoint_ramp.sv
// mash_setpoint_ramp
//   Captures the JTAG slave's 32-bit control word, derives an enable plus an
//   unsigned DATA_W-bit DAC setpoint, and slews the modulator input toward it.
//   One sample is offered per SAMPLE_DIV clocks on a valid/ready stream. Each
//   sample moves at most STEP_MAX away from the previous one.
//
//   Ports
//     aclk      in   sole clock, rising edge
//     areset    in   synchronous active-high reset
//     cfg_data  in   [31] enable, [DATA_W-1:0] target, [30:DATA_W] ignored
//     ovr_clr   in   one-cycle pulse, clears overrun (and ovr_cnt)
//     m_data    out  current sample to the MASH 1-1 modulator
//     m_valid   out  sample valid
//     m_ready   in   modulator accepts sample
//     busy      out  high while ramping
//     overrun   out  sticky: a tick found the previous sample still unaccepted
//     ovr_cnt   out  saturating overrun-tick count (only with MASH_RAMP_OVR_CNT_EN)
//
//   Build option: define MASH_RAMP_OVR_CNT_EN to add the ovr_cnt port and counter.
//
//   state    | meaning
//   ---------+----------------------------------------------------
//   S_IDLE   | out of reset, no tick evaluated yet
//   S_RAMP   | cur differs from target, stepping toward it
//   S_SETTLED| cur equals target, repeat samples are emitted

module mash_setpoint_ramp #(
  parameter int                DATA_W     = 24,
  parameter int                SAMPLE_DIV = 16,
  parameter logic [DATA_W-1:0] STEP_MAX   = 'h100
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [31:0]       cfg_data,
  input  logic              ovr_clr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              overrun
`ifdef MASH_RAMP_OVR_CNT_EN
  ,
  output logic [15:0]       ovr_cnt
`endif
);

  localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_SETTLED} state_t;

  state_t              state, state_nxt;
  logic [31:0]         cfg_q;
  logic [DATA_W-1:0]   target, cur, cur_step, cur_nxt, mag, step;
  logic [DIV_W-1:0]    div_cnt;
  logic signed [DATA_W:0] diff;
  logic [DATA_W:0]     diff_neg;
  logic                tick, stall, load;
  logic                unused_cfg;

  // Bits [30:DATA_W] carry nothing for this block.
  assign unused_cfg = ^cfg_data[30:0];

  assign tick  = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign stall = tick && m_valid && !m_ready;
  assign load  = tick && !(m_valid && !m_ready);

  // One extra bit keeps the full unsigned range difference exact, so the
  // clamped step can never overshoot or wrap.
  always_comb begin
    diff     = $signed({1'b0, target}) - $signed({1'b0, cur});
    diff_neg = -diff;
    mag      = diff[DATA_W] ? diff_neg[DATA_W-1:0] : diff[DATA_W-1:0];
    step     = (STEP_MAX == '0 || mag <= STEP_MAX) ? mag : STEP_MAX;
    cur_step = diff[DATA_W] ? (cur - step) : (cur + step);
    cur_nxt  = load ? cur_step : cur;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cfg_q   <= '0;
      target  <= '0;
      cur     <= '0;
      div_cnt <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      cfg_q <= cfg_data;
      if (cfg_data != cfg_q)
        target <= cfg_data[31] ? cfg_data[DATA_W-1:0] : '0;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (load) begin
        cur     <= cur_step;
        m_data  <= cur_step;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      // A new overrun wins over a simultaneous clear.
      if (stall)
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;
    end
  end

`ifdef MASH_RAMP_OVR_CNT_EN
  always_ff @(posedge aclk) begin
    if (areset)
      ovr_cnt <= '0;
    else if (stall)
      ovr_cnt <= ovr_clr ? 16'd1 : ((ovr_cnt == 16'hFFFF) ? ovr_cnt : ovr_cnt + 16'd1);
    else if (ovr_clr)
      ovr_cnt <= '0;
  end
`endif

  always_ff @(posedge aclk) begin
    if (areset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        S_IDLE:    state_nxt = (target != cur) ? S_RAMP : S_SETTLED;
        S_RAMP:    if (cur_nxt == target) state_nxt = S_SETTLED;
        S_SETTLED: if (target != cur) state_nxt = S_RAMP;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == S_RAMP);
  end

endmodule

// File: tb/tb_mash_setpoint_ramp.sv
module tb_mash_setpoint_ramp;
  localparam int DW = 24;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          b;
  } exp_t;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic          areset, ovr_clr, m_ready, m_valid, busy, overrun;
  logic [31:0]   cfg_data;
  logic [DW-1:0] m_data;
  logic          areset0, ovr_clr0, m_ready0, m_valid0, busy0, overrun0;
  logic [31:0]   cfg0;
  logic [DW-1:0] m_data0;
`ifdef MASH_RAMP_OVR_CNT_EN
  logic [15:0]   ovr_cnt, ovr_cnt0;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  logic [DW-1:0] exp0_q[$];
  time  last_t = 0;

  mash_setpoint_ramp #(.DATA_W(DW), .SAMPLE_DIV(4), .STEP_MAX(24'h100)) dut (
    .aclk(aclk), .areset(areset), .cfg_data(cfg_data), .ovr_clr(ovr_clr),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
    .overrun(overrun)
`ifdef MASH_RAMP_OVR_CNT_EN
    , .ovr_cnt(ovr_cnt)
`endif
  );

  mash_setpoint_ramp #(.DATA_W(DW), .SAMPLE_DIV(4), .STEP_MAX(24'h0)) dut0 (
    .aclk(aclk), .areset(areset0), .cfg_data(cfg0), .ovr_clr(ovr_clr0),
    .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready0), .busy(busy0),
    .overrun(overrun0)
`ifdef MASH_RAMP_OVR_CNT_EN
    , .ovr_cnt(ovr_cnt0)
`endif
  );

  // Waits for an accepted sample on the main instance, returns after the accepting edge.
  task automatic get_sample(output logic [DW-1:0] d, output logic b, output int gap);
    int n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!(m_valid && m_ready) && n < 64);
    if (!(m_valid && m_ready)) begin
      vectors++;
      miscompares++;
      $display("FAIL sample_timeout: no sample within %0d cycles", n);
      d = 'x; b = 1'bx; gap = 0;
    end else begin
      d = m_data; b = busy;
      gap = int'(($time - last_t) / 10);
      last_t = $time;
    end
    @(posedge aclk); #1;
  endtask

  task automatic get_sample0(output logic [DW-1:0] d);
    int n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!m_valid0 && n < 64);
    if (!m_valid0) begin
      vectors++;
      miscompares++;
      $display("FAIL sample0_timeout: no sample within %0d cycles", n);
      d = 'x;
    end else begin
      d = m_data0;
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_reset();
    exp_t e; logic [DW-1:0] d; logic b; int g;
    areset = 1'b1; cfg_data = '0; ovr_clr = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      vectors++;
      if ({m_valid, busy, overrun, m_data} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs cyc%0d: got v=%b busy=%b ovr=%b data=%h, want all 0",
                 i, m_valid, busy, overrun, m_data);
      end
    end
    areset = 1'b0;
    repeat (3) exp_q.push_back(exp_t'{d: '0, b: 1'b0});
    for (int i = 0; i < 3; i++) begin
      get_sample(d, b, g);
      e = exp_q.pop_front();
      vectors++;
      if (d !== e.d) begin miscompares++; $display("FAIL idle_data #%0d: got %h want %h", i, d, e.d); end
      vectors++;
      if (b !== e.b) begin miscompares++; $display("FAIL idle_busy #%0d: got %b want %b", i, b, e.b); end
      if (i > 0) begin
        vectors++;
        if (g !== 4) begin miscompares++; $display("FAIL tick_period #%0d: got %0d want 4", i, g); end
      end
    end
  endtask

  task automatic test_ramp_up();
    exp_t e; logic [DW-1:0] d; logic b; int g;
    cfg_data = 32'h8000_0400;
    exp_q.push_back(exp_t'{d: 24'h100, b: 1'b1});
    exp_q.push_back(exp_t'{d: 24'h200, b: 1'b1});
    exp_q.push_back(exp_t'{d: 24'h300, b: 1'b1});
    exp_q.push_back(exp_t'{d: 24'h400, b: 1'b0});
    exp_q.push_back(exp_t'{d: 24'h400, b: 1'b0});
    for (int i = 0; i < 5; i++) begin
      get_sample(d, b, g);
      e = exp_q.pop_front();
      vectors++;
      if (d !== e.d) begin miscompares++; $display("FAIL ramp_up_data #%0d: got %h want %h", i, d, e.d); end
      vectors++;
      if (b !== e.b) begin miscompares++; $display("FAIL ramp_up_busy #%0d: got %b want %b", i, b, e.b); end
    end
  endtask

  task automatic test_retarget();
    exp_t e; logic [DW-1:0] d; logic b; int g;
    cfg_data = 32'h8000_0200;
    exp_q.push_back(exp_t'{d: 24'h300, b: 1'b1});
    exp_q.push_back(exp_t'{d: 24'h200, b: 1'b0});
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        cfg_data = 32'h8000_0080;
        exp_q.push_back(exp_t'{d: 24'h100, b: 1'b1});
        exp_q.push_back(exp_t'{d: 24'h080, b: 1'b0});
        exp_q.push_back(exp_t'{d: 24'h080, b: 1'b0});
      end
      get_sample(d, b, g);
      e = exp_q.pop_front();
      vectors++;
      if (d !== e.d) begin miscompares++; $display("FAIL retarget_data #%0d: got %h want %h", i, d, e.d); end
      vectors++;
      if (b !== e.b) begin miscompares++; $display("FAIL retarget_busy #%0d: got %b want %b", i, b, e.b); end
    end
  endtask

  task automatic test_disable();
    exp_t e; logic [DW-1:0] d; logic b; int g;
    logic [DW-1:0] up [4] = '{24'h180, 24'h280, 24'h380, 24'h400};
    logic [DW-1:0] dn [5] = '{24'h300, 24'h200, 24'h100, 24'h000, 24'h000};
    cfg_data = 32'h8000_0400;
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_t'{d: up[i], b: (i < 3)});
    for (int i = 0; i < 9; i++) begin
      if (i == 4) begin
        cfg_data = 32'h0000_0400;
        for (int j = 0; j < 5; j++) exp_q.push_back(exp_t'{d: dn[j], b: (j < 3)});
      end
      get_sample(d, b, g);
      e = exp_q.pop_front();
      vectors++;
      if (d !== e.d) begin miscompares++; $display("FAIL disable_data #%0d: got %h want %h", i, d, e.d); end
      vectors++;
      if (b !== e.b) begin miscompares++; $display("FAIL disable_busy #%0d: got %b want %b", i, b, e.b); end
    end
  endtask

  task automatic test_overrun();
    exp_t e; logic [DW-1:0] d; logic b; int g;
    cfg_data = 32'h8000_0400;
    exp_q.push_back(exp_t'{d: 24'h100, b: 1'b1});
    get_sample(d, b, g);
    e = exp_q.pop_front();
    vectors++;
    if (d !== e.d) begin miscompares++; $display("FAIL ovr_first_data: got %h want %h", d, e.d); end
    // Three ticks with ready low: one loads 0x200, two find it unaccepted.
    m_ready = 1'b0;
    repeat (12) @(posedge aclk);
    #1;
    vectors++;
    if ({m_valid, overrun, busy} !== 3'b111) begin
      miscompares++;
      $display("FAIL ovr_flags: got v=%b ovr=%b busy=%b want 1 1 1", m_valid, overrun, busy);
    end
    vectors++;
    if (m_data !== 24'h200) begin miscompares++; $display("FAIL ovr_hold_data: got %h want 200", m_data); end
`ifdef MASH_RAMP_OVR_CNT_EN
    vectors++;
    if (ovr_cnt !== 16'd2) begin miscompares++; $display("FAIL ovr_cnt_two: got %0d want 2", ovr_cnt); end
`endif
    exp_q.push_back(exp_t'{d: 24'h200, b: 1'b1});
    exp_q.push_back(exp_t'{d: 24'h300, b: 1'b1});
    m_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      get_sample(d, b, g);
      e = exp_q.pop_front();
      vectors++;
      if (d !== e.d) begin miscompares++; $display("FAIL ovr_resume_data #%0d: got %h want %h", i, d, e.d); end
    end
    vectors++;
    if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    ovr_clr = 1'b1;
    @(posedge aclk); #1;
    ovr_clr = 1'b0;
    vectors++;
    if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_clear: got %b want 0", overrun); end
`ifdef MASH_RAMP_OVR_CNT_EN
    vectors++;
    if (ovr_cnt !== 16'd0) begin miscompares++; $display("FAIL ovr_cnt_clear: got %0d want 0", ovr_cnt); end
`endif
    // Clear and a fresh overrun on the same edge: the overrun wins.
    m_ready = 1'b0;
    repeat (5) @(posedge aclk);
    #1;
    ovr_clr = 1'b1;
    @(posedge aclk); #1;
    ovr_clr = 1'b0;
    vectors++;
    if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_clr_collide: got %b want 1", overrun); end
`ifdef MASH_RAMP_OVR_CNT_EN
    vectors++;
    if (ovr_cnt !== 16'd1) begin miscompares++; $display("FAIL ovr_cnt_collide: got %0d want 1", ovr_cnt); end
`endif
    exp_q.push_back(exp_t'{d: 24'h400, b: 1'b0});
    m_ready = 1'b1;
    get_sample(d, b, g);
    e = exp_q.pop_front();
    vectors++;
    if (d !== e.d) begin miscompares++; $display("FAIL ovr_last_data: got %h want %h", d, e.d); end
    vectors++;
    if (b !== e.b) begin miscompares++; $display("FAIL ovr_last_busy: got %b want %b", b, e.b); end
    ovr_clr = 1'b1;
    @(posedge aclk); #1;
    ovr_clr = 1'b0;
  endtask

  task automatic test_reset_midramp();
    exp_t e; logic [DW-1:0] d; logic b; int g;
    cfg_data = 32'h8000_0800;
    exp_q.push_back(exp_t'{d: 24'h500, b: 1'b1});
    get_sample(d, b, g);
    e = exp_q.pop_front();
    vectors++;
    if (d !== e.d) begin miscompares++; $display("FAIL midramp_pre_data: got %h want %h", d, e.d); end
    // Reset lands on the edge that would otherwise emit 0x600.
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk); #1;
    vectors++;
    if ({m_valid, busy, overrun, m_data} !== '0) begin
      miscompares++;
      $display("FAIL midramp_reset: got v=%b busy=%b ovr=%b data=%h, want all 0",
               m_valid, busy, overrun, m_data);
    end
    areset = 1'b0;
    exp_q.push_back(exp_t'{d: 24'h100, b: 1'b1});
    get_sample(d, b, g);
    e = exp_q.pop_front();
    vectors++;
    if (d !== e.d) begin miscompares++; $display("FAIL midramp_restart_data: got %h want %h", d, e.d); end
    vectors++;
    if (b !== e.b) begin miscompares++; $display("FAIL midramp_restart_busy: got %b want %b", b, e.b); end
  endtask

  task automatic test_no_limit();
    logic [DW-1:0] d, e;
    vectors++;
    if ({m_valid0, busy0, overrun0, m_data0} !== '0) begin
      miscompares++;
      $display("FAIL nolim_reset: got v=%b busy=%b ovr=%b data=%h, want all 0",
               m_valid0, busy0, overrun0, m_data0);
    end
    areset0 = 1'b0;
    cfg0 = 32'h80FF_FFFF;
    exp0_q.push_back(24'hFF_FFFF);
    get_sample0(d);
    e = exp0_q.pop_front();
    vectors++;
    if (d !== e) begin miscompares++; $display("FAIL nolim_jump_up: got %h want %h", d, e); end
    cfg0 = 32'h8000_0010;
    exp0_q.push_back(24'h00_0010);
    get_sample0(d);
    e = exp0_q.pop_front();
    vectors++;
    if (d !== e) begin miscompares++; $display("FAIL nolim_jump_down: got %h want %h", d, e); end
    cfg0 = 32'h7FFF_FFFF;
    exp0_q.push_back(24'h00_0000);
    get_sample0(d);
    e = exp0_q.pop_front();
    vectors++;
    if (d !== e) begin miscompares++; $display("FAIL nolim_disable: got %h want %h", d, e); end
    vectors++;
    if (overrun0 !== 1'b0) begin miscompares++; $display("FAIL nolim_overrun: got %b want 0", overrun0); end
`ifdef MASH_RAMP_OVR_CNT_EN
    vectors++;
    if (ovr_cnt0 !== 16'd0) begin miscompares++; $display("FAIL nolim_ovr_cnt: got %0d want 0", ovr_cnt0); end
`endif
  endtask

  initial begin
    areset = 1'b1; cfg_data = '0; ovr_clr = 1'b0; m_ready = 1'b1;
    areset0 = 1'b1; cfg0 = '0; ovr_clr0 = 1'b0; m_ready0 = 1'b1;
    test_reset();
    test_ramp_up();
    test_retarget();
    test_disable();
    test_overrun();
    test_reset_midramp();
    test_no_limit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
